// File: rtl/cve2_obi_responder.sv
// OBI-style memory responder: configurable grant stall, response latency and
// outstanding-request limit, with byte-enabled word storage.
module cve2_obi_responder #(
  parameter int unsigned MemWords       = 1024,
  parameter logic [31:0] BaseAddr       = 32'h0000_0000,
  parameter int unsigned GntDelay       = 0,
  parameter int unsigned RespLatency    = 1,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int unsigned AW      = $clog2(MemWords);
  localparam logic [2:0]  GNT_DLY = 3'(GntDelay);
  localparam logic [2:0]  MAX_OUT = 3'(MaxOutstanding);

  typedef enum logic {IDLE, STALL} state_e;

  state_e            state;
  logic [2:0]        wait_cnt;
  logic [2:0]        cnt_inc;
  logic [2:0]        outstanding;
  logic              slot_free;
  logic [31:0]       offset;
  logic              in_range;
  logic [AW-1:0]     word_idx;
  logic [31:0]       mem [MemWords];

  logic [RespLatency-1:0] pipe_valid;
  logic [RespLatency-1:0] pipe_err;
  logic [31:0]            pipe_rdata [RespLatency];

  assign offset   = addr_i - BaseAddr;
  assign in_range = (offset >> 2) < 32'(MemWords);
  assign word_idx = offset[AW+1:2];
  assign cnt_inc  = (wait_cnt == GNT_DLY) ? wait_cnt : wait_cnt + 3'd1;

  // A response retiring this cycle frees its slot for a same-cycle grant.
  assign slot_free = (outstanding < MAX_OUT) || rvalid_o;
  assign gnt_o     = rst_ni && req_i && (wait_cnt == GNT_DLY) && slot_free;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_i && !gnt_o) begin
            state    <= STALL;
            wait_cnt <= cnt_inc;
          end
        end
        STALL: begin
          if (!req_i || gnt_o) begin
            state    <= IDLE;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= cnt_inc;
          end
        end
        default: begin
          state    <= IDLE;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding <= '0;
    end else begin
      case ({gnt_o, rvalid_o})
        2'b10:   outstanding <= outstanding + 3'd1;
        2'b01:   outstanding <= outstanding - 3'd1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (gnt_o && we_i && in_range) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be_i[b]) mem[word_idx][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  // Idle stages carry zeros so rdata/err are clean whenever rvalid is low.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_valid <= '0;
      pipe_err   <= '0;
      for (int unsigned i = 0; i < RespLatency; i++) pipe_rdata[i] <= '0;
    end else begin
      pipe_valid[0] <= gnt_o;
      pipe_err[0]   <= gnt_o && !in_range;
      pipe_rdata[0] <= (gnt_o && !we_i && in_range) ? mem[word_idx] : '0;
      for (int unsigned i = 1; i < RespLatency; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_err[i]   <= pipe_err[i-1];
        pipe_rdata[i] <= pipe_rdata[i-1];
      end
    end
  end

  assign rvalid_o = pipe_valid[RespLatency-1];
  assign err_o    = pipe_err[RespLatency-1];
  assign rdata_o  = pipe_rdata[RespLatency-1];

endmodule
